// File: rtl/legv8_datapath_rm_pkg.sv
// Shared control-word field map, ALU function codes and status bit layout for the LEGv8 datapath.
package legv8_datapath_rm_pkg;

    localparam int CW_W       = 34;
    localparam int CW_PCLOAD  = 33;
    localparam int CW_BUS_MSB = 32;
    localparam int CW_PCS_MSB = 30;
    localparam int CW_PCOUT   = 28;
    localparam int CW_BSEL    = 27;
    localparam int CW_IRLOAD  = 26;
    localparam int CW_SLOAD   = 25;
    localparam int CW_FS_MSB  = 24;
    localparam int CW_C0      = 19;
    localparam int CW_MEMW    = 16;
    localparam int CW_REGW    = 15;
    localparam int CW_DA_MSB  = 14;
    localparam int CW_SA_MSB  = 9;
    localparam int CW_SB_MSB  = 4;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_LSL   = 3'b100;
    localparam logic [2:0] OP_LSR   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    localparam logic [1:0] BUS_ALU  = 2'b00;
    localparam logic [1:0] BUS_REGB = 2'b01;
    localparam logic [1:0] BUS_NONE = 2'b10;
    localparam logic [1:0] BUS_RAM  = 2'b11;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC4 = 2'b01;
    localparam logic [1:0] PC_REGA = 2'b10;
    localparam logic [1:0] PC_REL  = 2'b11;

    localparam int ST_BZ = 0;
    localparam int ST_Z  = 1;
    localparam int ST_N  = 2;
    localparam int ST_C  = 3;
    localparam int ST_V  = 4;

endpackage

// File: rtl/legv8_datapath_rm_alu.sv
// 64-bit LEGv8 function unit: optional operand inversion, eight ops, N/Z always, C/V from the adder only.
// Purely combinational; no state, no backpressure.
module legv8_alu
    import legv8_datapath_rm_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [4:0]  fs,
    input  logic        c0,
    output logic [63:0] f,
    output logic        v,
    output logic        c,
    output logic        n,
    output logic        z
);

    logic [63:0] a_i;
    logic [63:0] b_i;
    logic [64:0] sum;

    assign a_i = fs[1] ? ~a : a;
    assign b_i = fs[0] ? ~b : b;
    assign sum = {1'b0, a_i} + {1'b0, b_i} + {64'd0, c0};

    always_comb begin
        f = 64'd0;
        v = 1'b0;
        c = 1'b0;
        unique case (fs[4:2])
            OP_AND:   f = a_i & b_i;
            OP_OR:    f = a_i | b_i;
            OP_ADD: begin
                f = sum[63:0];
                c = sum[64];
                // Signed overflow: operands agree in sign but the result does not.
                v = (a_i[63] == b_i[63]) && (sum[63] != a_i[63]);
            end
            OP_XOR:   f = a_i ^ b_i;
            OP_LSL:   f = a_i << b_i[5:0];
            OP_LSR:   f = a_i >> b_i[5:0];
            OP_PASSA: f = a_i;
            OP_PASSB: f = b_i;
            default:  f = 64'd0;
        endcase
    end

    assign n = f[63];
    assign z = (f == 64'd0);

endmodule

// File: rtl/legv8_datapath_rm.sv
// Microcoded LEGv8 datapath: register file, ALU, RAM, PC and IR around one shared tri-state bus.
// Single-cycle micro-ops; status/address combinational, all state on the rising clock; no backpressure.
module legv8_datapath_rm
    import legv8_datapath_rm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [CW_W-1:0]   ControlWord,
    inout  wire  [63:0]       data,
    output logic [31:0]       address,
    input  logic [63:0]       constant,
    output logic [4:0]        status,
    output logic [31:0]       IR_out,
    output logic [3:0]        current_status,
    output logic [15:0]       r0,
    output logic [15:0]       r1,
    output logic [15:0]       r2,
    output logic [15:0]       r3,
    output logic [15:0]       r4,
    output logic [15:0]       r5,
    output logic [15:0]       r6,
    output logic [15:0]       r7
);

    logic        pc_load, pc_out, b_sel, ir_load, s_load, c0, mem_write, reg_write;
    logic [1:0]  bus_sel, pc_sel;
    logic [4:0]  fs, da, sa, sb;

    assign pc_load   = ControlWord[CW_PCLOAD];
    assign bus_sel   = ControlWord[CW_BUS_MSB -: 2];
    assign pc_sel    = ControlWord[CW_PCS_MSB -: 2];
    assign pc_out    = ControlWord[CW_PCOUT];
    assign b_sel     = ControlWord[CW_BSEL];
    assign ir_load   = ControlWord[CW_IRLOAD];
    assign s_load    = ControlWord[CW_SLOAD];
    assign fs        = ControlWord[CW_FS_MSB -: 5];
    assign c0        = ControlWord[CW_C0];
    assign mem_write = ControlWord[CW_MEMW];
    assign reg_write = ControlWord[CW_REGW];
    assign da        = ControlWord[CW_DA_MSB -: 5];
    assign sa        = ControlWord[CW_SA_MSB -: 5];
    assign sb        = ControlWord[CW_SB_MSB -: 5];

    logic unused_reserved;
    assign unused_reserved = &{1'b0, ControlWord[18:17]};

    logic [63:0] regs [0:31];
    logic [63:0] mem  [0:127];
    logic [63:0] pc, pc_next;
    logic [31:0] ir;
    logic [3:0]  cstat;

    logic [63:0] rd_a, rd_b, alu_b, alu_f, ram_rd;
    logic        v, c, n, z;

    // R31 is the zero register: its storage exists but is never read or written.
    assign rd_a  = (sa == 5'd31) ? 64'd0 : regs[sa];
    assign rd_b  = (sb == 5'd31) ? 64'd0 : regs[sb];
    assign alu_b = b_sel ? constant : rd_b;

    legv8_alu u_alu (
        .a  (rd_a),
        .b  (alu_b),
        .fs (fs),
        .c0 (c0),
        .f  (alu_f),
        .v  (v),
        .c  (c),
        .n  (n),
        .z  (z)
    );

    assign address = alu_f[31:0];
    assign status  = {v, c, n, z, (rd_b == 64'd0)};
    assign ram_rd  = mem[address[9:3]];

    logic        bus_en;
    logic [63:0] bus_drv;

    always_comb begin
        bus_en  = 1'b1;
        bus_drv = 64'd0;
        if (pc_out) begin
            bus_drv = pc;
        end else begin
            unique case (bus_sel)
                BUS_ALU:  bus_drv = alu_f;
                BUS_REGB: bus_drv = rd_b;
                BUS_RAM:  bus_drv = ram_rd;
                default:  bus_en  = 1'b0;
            endcase
        end
    end

    assign data = bus_en ? bus_drv : 64'bz;

    always_comb begin
        pc_next = pc;
        unique case (pc_sel)
            PC_HOLD: pc_next = pc;
            PC_INC4: pc_next = pc + 64'd4;
            PC_REGA: pc_next = rd_a;
            PC_REL:  pc_next = pc + (constant << 2);
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
            pc    <= 64'd0;
            ir    <= 32'd0;
            cstat <= 4'd0;
        end else begin
            if (reg_write && (da != 5'd31)) regs[da] <= data;
            if (pc_load) pc <= pc_next;
            if (ir_load) ir <= data[31:0];
            if (s_load)  cstat <= status[ST_V:ST_Z];
        end
    end

    // RAM keeps its contents through reset; reset only suppresses the write.
    always_ff @(posedge clock) begin
        if (mem_write && reset) mem[address[9:3]] <= data;
    end

    assign IR_out         = ir;
    assign current_status = cstat;
    assign r0 = regs[0][15:0];
    assign r1 = regs[1][15:0];
    assign r2 = regs[2][15:0];
    assign r3 = regs[3][15:0];
    assign r4 = regs[4][15:0];
    assign r5 = regs[5][15:0];
    assign r6 = regs[6][15:0];
    assign r7 = regs[7][15:0];

endmodule

// File: tb/tb_legv8_datapath_rm.sv
// Scoreboard bench for legv8_datapath_rm: expectations queued per micro-op, compared same-cycle or after the edge.
module tb_legv8_datapath_rm;

    logic        clock = 1'b0;
    logic        reset;
    logic [33:0] ControlWord;
    wire  [63:0] data;
    logic [31:0] address;
    logic [63:0] constant;
    logic [4:0]  status;
    logic [31:0] IR_out;
    logic [3:0]  current_status;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    legv8_datapath_rm dut (
        .clock          (clock),
        .reset          (reset),
        .ControlWord    (ControlWord),
        .data           (data),
        .address        (address),
        .constant       (constant),
        .status         (status),
        .IR_out         (IR_out),
        .current_status (current_status),
        .r0 (r0), .r1 (r1), .r2 (r2), .r3 (r3),
        .r4 (r4), .r5 (r5), .r6 (r6), .r7 (r7)
    );

    always #5 clock = ~clock;

    localparam int O_STATUS = 8, O_ADDR = 9, O_DATA = 10, O_IR = 11, O_CSTAT = 12;

    localparam logic [4:0] F_AND = 5'b00000, F_OR = 5'b00100, F_ADD = 5'b01000,
                           F_SUB = 5'b01001, F_XOR = 5'b01100, F_LSL = 5'b10000,
                           F_LSR = 5'b10100, F_PA = 5'b11000, F_PB = 5'b11100,
                           F_NOTA = 5'b11010;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_comb[$];
    exp_t exp_seq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_obs(input int sel);
        case (sel)
            0: return {48'd0, r0};
            1: return {48'd0, r1};
            2: return {48'd0, r2};
            3: return {48'd0, r3};
            4: return {48'd0, r4};
            5: return {48'd0, r5};
            6: return {48'd0, r6};
            7: return {48'd0, r7};
            O_STATUS: return {59'd0, status};
            O_ADDR:   return {32'd0, address};
            O_DATA:   return data;
            O_IR:     return {32'd0, IR_out};
            O_CSTAT:  return {60'd0, current_status};
            default:  return 64'hDEAD;
        endcase
    endfunction

    task automatic expc(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = val;
        exp_comb.push_back(e);
    endtask

    task automatic exps(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = val;
        exp_seq.push_back(e);
    endtask

    task automatic drain_comb();
        exp_t e;
        while (exp_comb.size() > 0) begin
            e = exp_comb.pop_front();
            chk(e.tag, get_obs(e.sel), e.exp);
        end
    endtask

    task automatic drain_seq();
        exp_t e;
        while (exp_seq.size() > 0) begin
            e = exp_seq.pop_front();
            chk(e.tag, get_obs(e.sel), e.exp);
        end
    endtask

    function automatic logic [33:0] cw(input logic pcload, input logic [1:0] bus, input logic [1:0] pcs,
                                       input logic pcout, input logic bsel, input logic irl, input logic sl,
                                       input logic [4:0] fs, input logic c0, input logic mw, input logic rw,
                                       input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
        return {pcload, bus, pcs, pcout, bsel, irl, sl, fs, c0, 2'b11, mw, rw, da, sa, sb};
    endfunction

    // Drive one micro-op, check combinational expectations, clock it, check registered ones.
    task automatic apply(input logic [33:0] w, input logic [63:0] k);
        ControlWord = w;
        constant    = k;
        #1;
        drain_comb();
        @(posedge clock);
        #1;
        drain_seq();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        ControlWord = cw(0, 2'b10, 2'b00, 0, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0);
        constant    = 64'd0;
        #2;
        chk("reset_r0", get_obs(0), 64'd0);
        chk("reset_ir", get_obs(O_IR), 64'd0);
        chk("reset_cstat", get_obs(O_CSTAT), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        exps("orr_r0", 0, 64'h0018);
        apply(cw(0, 2'b00, 2'b00, 0, 1, 0, 0, F_OR, 0, 0, 1, 0, 31, 0), 64'd24);

        expc("sub_status", O_STATUS, 64'b00100);
        exps("sub_r1", 1, 64'hFFE8);
        exps("sub_cstat", O_CSTAT, 64'b0010);
        apply(cw(0, 2'b00, 2'b00, 0, 0, 0, 1, F_SUB, 1, 0, 1, 1, 31, 0), 64'h6000_0018);

        expc("st_addr", O_ADDR, 64'h6000_0018);
        expc("st_bus", O_DATA, 64'hFFFF_FFFF_FFFF_FFE8);
        apply(cw(0, 2'b01, 2'b00, 0, 1, 0, 0, F_ADD, 0, 1, 0, 0, 31, 1), 64'h6000_0018);

        exps("and_r1", 1, 64'h0008);
        apply(cw(0, 2'b00, 2'b00, 0, 0, 0, 0, F_AND, 0, 0, 1, 1, 0, 1), 64'd0);

        expc("ld_bus", O_DATA, 64'hFFFF_FFFF_FFFF_FFE8);
        exps("ld_r2", 2, 64'hFFE8);
        apply(cw(0, 2'b11, 2'b00, 0, 1, 0, 0, F_ADD, 0, 0, 1, 2, 31, 0), 64'h6000_0018);

        exps("ir_load", O_IR, 64'h0000_0008);
        apply(cw(0, 2'b01, 2'b00, 0, 0, 1, 0, F_AND, 0, 0, 0, 0, 0, 1), 64'd0);

        exps("lsl_r3", 3, 64'h0080);
        apply(cw(0, 2'b00, 2'b00, 0, 1, 0, 0, F_LSL, 0, 0, 1, 3, 1, 0), 64'd4);

        exps("lsr_r4", 4, 64'h000F);
        apply(cw(0, 2'b00, 2'b00, 0, 1, 0, 0, F_LSR, 0, 0, 1, 4, 2, 0), 64'd60);

        exps("xor_r5", 5, 64'hFFF0);
        apply(cw(0, 2'b00, 2'b00, 0, 0, 0, 0, F_XOR, 0, 0, 1, 5, 0, 2), 64'd0);

        exps("passb_r6", 6, 64'hFFFF);
        apply(cw(0, 2'b00, 2'b00, 0, 1, 0, 0, F_PB, 0, 0, 1, 6, 31, 0), 64'h7FFF_FFFF_FFFF_FFFF);

        expc("ovf_status", O_STATUS, 64'b10100);
        exps("ovf_r7", 7, 64'hFFFE);
        exps("ovf_cstat", O_CSTAT, 64'b1010);
        apply(cw(0, 2'b00, 2'b00, 0, 0, 0, 1, F_ADD, 0, 0, 1, 7, 6, 6), 64'd0);

        expc("carry_status", O_STATUS, 64'b01011);
        expc("carry_addr", O_ADDR, 64'd0);
        exps("carry_cstat", O_CSTAT, 64'b0101);
        apply(cw(0, 2'b00, 2'b00, 0, 1, 0, 1, F_ADD, 0, 0, 1, 31, 2, 31), 64'h18);

        expc("r31_zero", O_DATA, 64'd0);
        apply(cw(0, 2'b01, 2'b00, 0, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 31), 64'd0);

        expc("nota_addr", O_ADDR, 64'hFFFF_FFFF);
        apply(cw(0, 2'b10, 2'b00, 0, 0, 0, 0, F_NOTA, 0, 0, 0, 0, 31, 0), 64'd0);

        expc("pc_hold", O_DATA, 64'd0);
        apply(cw(1, 2'b10, 2'b00, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'd0);
        expc("pc_pre_inc", O_DATA, 64'd0);
        apply(cw(1, 2'b10, 2'b01, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'd0);
        expc("pc_inc4", O_DATA, 64'd4);
        apply(cw(1, 2'b10, 2'b10, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 1, 0), 64'd0);
        expc("pc_rega", O_DATA, 64'd8);
        apply(cw(1, 2'b10, 2'b11, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'd2);
        expc("pc_rel", O_DATA, 64'd16);
        apply(cw(1, 2'b00, 2'b11, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'hFFFF_FFFF_FFFF_FFFC);
        expc("pc_wrap", O_DATA, 64'd0);
        apply(cw(0, 2'b00, 2'b00, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'd0);

        // Mid-run reset with a register write pending on the next edge.
        ControlWord = cw(0, 2'b00, 2'b00, 0, 0, 0, 1, F_PA, 0, 1, 1, 0, 6, 0);
        constant    = 64'd0;
        reset       = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            expc($sformatf("rst_r%0d", i), i, 64'd0);
        end
        expc("rst_ir", O_IR, 64'd0);
        expc("rst_cstat", O_CSTAT, 64'd0);
        drain_comb();
        @(posedge clock); #1;
        chk("rst_write_blocked", get_obs(0), 64'd0);
        reset = 1'b1;

        expc("ram_kept", O_DATA, 64'hFFFF_FFFF_FFFF_FFE8);
        apply(cw(0, 2'b11, 2'b00, 0, 1, 0, 0, F_ADD, 0, 0, 0, 0, 31, 0), 64'h18);
        expc("rst_pc", O_DATA, 64'd0);
        apply(cw(0, 2'b00, 2'b00, 1, 0, 0, 0, F_AND, 0, 0, 0, 0, 0, 0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
